alu_issue_q: RTL and testbench

- Operand issue queue and result capture stage wrapped around the combinational add_sub datapath.
- Buffers operand pairs (a, b, sign) from the decode side in a FIFO and drives the queue head onto add_sub x/y/sign.
- Registers add_sub z into a valid/ready output stage feeding writeback.
- Decouples upstream and downstream back-pressure from the single-cycle arithmetic.

---
 rtl/alu_issue_q.sv | 89 ++++++++
 tb/tb_alu_issue_q.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_q.sv
// Operand issue queue feeding a combinational add/sub datapath, plus a registered
// valid/ready result stage so upstream and downstream stalls never touch the arithmetic.

module add_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sign,
  output logic [WIDTH-1:0] z
);
  // Modulo 2^WIDTH; no carry or overflow is reported.
  assign z = sign ? (x - y) : (x + y);
endmodule

module alu_issue_q #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       in_sign,
  output logic [WIDTH-1:0]           x,
  output logic [WIDTH-1:0]           y,
  output logic                       sign,
  input  logic [WIDTH-1:0]           z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_res,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, empty;
  entry_t          head;

  assign empty    = (count == '0);
  // No full-cycle bypass: a pop in the same cycle does not open a slot.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  assign head = empty ? '0 : mem[rd_ptr];
  assign x    = head.a;
  assign y    = head.b;
  assign sign = head.sign;

  // Storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{a: in_a, b: in_b, sign: in_sign};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_res   <= z;
        out_valid <= 1'b1;
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_q.sv
// Directed bench for alu_issue_q: queue-level reference model checked every cycle,
// plus literal expectations at the points the scenarios call out.

module tb_alu_issue_q;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic             in_sign = 1'b0;
  logic [WIDTH-1:0] x, y, z;
  logic             sign;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_res;
  logic [2:0]       count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign(in_sign),
    .x(x), .y(y), .sign(sign), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .count(count)
  );

  add_sub #(.WIDTH(WIDTH)) u_add_sub (.x(x), .y(y), .sign(sign), .z(z));

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
  } pair_t;

  pair_t            q[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_res = '0;

  function automatic logic [WIDTH-1:0] calc(pair_t p);
    return p.s ? p.a - p.b : p.a + p.b;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of pairs and one output slot.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_res   = '0;
    end else begin
      bit do_push, do_pop;
      pair_t p;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && (!m_valid || out_ready);
      if (do_pop) begin
        m_res   = calc(q[0]);
        m_valid = 1'b1;
        void'(q.pop_front());
      end else if (out_ready && m_valid) begin
        m_valid = 1'b0;
      end
      if (do_push) begin
        p.a = in_a; p.b = in_b; p.s = in_sign;
        q.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 64'(count), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_res", 64'(out_res), 64'(m_res));
      if (q.size() != 0) begin
        check("head_x", 64'(x), 64'(q[0].a));
        check("head_y", 64'(y), 64'(q[0].b));
        check("head_sign", 64'(sign), 64'(q[0].s));
      end else begin
        check("empty_xy", {x, y}, 64'd0);
        check("empty_sign", 64'(sign), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic s);
    in_valid = v; in_a = a; in_b = b; in_sign = s;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);

    // Single add 5+7
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd7, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    check("add_lat_valid", 64'(out_valid), 64'd0);
    check("add_lat_count", 64'(count), 64'd1);
    cyc();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_res", 64'(out_res), 64'd12);
    check("add_count", 64'(count), 64'd0);

    // Wrap cases back to back
    drive(1'b1, 32'd3, 32'd5, 1'b1);
    cyc();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    check("sub_wrap", 64'(out_res), 64'hFFFF_FFFE);
    cyc();
    check("add_wrap", 64'(out_res), 64'd0);
    check("add_wrap_valid", 64'(out_valid), 64'd1);
    cyc();
    check("drained_valid", 64'(out_valid), 64'd0);

    // Fill with output stalled: i+i for i=1..5
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 32'(i), 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_res", 64'(out_res), 64'd2);
    check("fill_head_x", 64'(x), 64'd2);

    // Stall hold, with a push attempt against a full queue
    drive(1'b1, 32'd99, 32'd99, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_res", 64'(out_res), 64'd2);
      check("hold_count", 64'(count), 64'd4);
      check("hold_head_x", 64'(x), 64'd2);
    end

    // Release: full queue pops but refuses the push that same cycle
    drive(1'b1, 32'd50, 32'd50, 1'b0);
    out_ready = 1'b1;
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    check("full_pop_res", 64'(out_res), 64'd4);
    check("full_pop_count", 64'(count), 64'd3);
    for (int k = 3; k <= 5; k++) begin
      cyc();
      check("drain_res", 64'(out_res), 64'(2 * k));
    end
    cyc();
    check("drain_done", 64'(out_valid), 64'd0);

    // Simultaneous push/pop at count=2
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd1, 1'b1);
    cyc();
    drive(1'b1, 32'd20, 32'd2, 1'b1);
    cyc();
    drive(1'b1, 32'd30, 32'd3, 1'b1);
    cyc();
    check("pp_pre_count", 64'(count), 64'd2);
    check("pp_pre_res", 64'(out_res), 64'd9);
    out_ready = 1'b1;
    drive(1'b1, 32'd40, 32'd4, 1'b1);
    cyc();
    check("pp_count", 64'(count), 64'd2);
    check("pp_res", 64'(out_res), 64'd18);
    drive(1'b1, 32'd7, 32'd8, 1'b0);
    cyc();
    check("pp_count2", 64'(count), 64'd2);
    check("pp_res2", 64'(out_res), 64'd27);
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    check("pp_res3", 64'(out_res), 64'd36);
    cyc();
    check("pp_res4", 64'(out_res), 64'd15);
    cyc();
    check("pp_idle", 64'(out_valid), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(100 * i), 32'd1, 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("mid_count", 64'(count), 64'd3);
    check("mid_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_res", 64'(out_res), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("no_stale", 64'(out_valid), 64'd0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
